lvds_link_trainer: RTL and testbench
====================================

Name: lvds_link_trainer

Overview:
- Sits directly downstream of the 8:1 LVDS deserializer, in the clk_parallel domain.
- Consumes the deserializer's 8-bit parallel word and drives its 9-bit IDELAY tap input.
- During training it sweeps IDELAY taps against a repeating training word, finds the widest passing eye, centres the tap and determines word rotation.
- Once locked, it outputs word-aligned data with a valid flag.

Parameters:
- PATTERN, 8'h5C, training word; must have period 8 so all 8 rotations are distinct.
- TAP_INIT, 256, idelay_tap value at reset, in IDLE and after FAIL.
- TAP_STEP, 8, sweep increment in taps.
- TAP_MAX, 511, last tap swept (inclusive).
- SETTLE_CYCLES, 8, cycles waited after any tap change before sampling (covers IDELAY update plus deserializer pipeline).
- SAMPLE_CYCLES, 16, consecutive words checked per tap point.
- MIN_EYE_PTS, 4, minimum passing run length (in tap points) required to lock.

Ports:
- clk_parallel, in, 1, parallel word clock.
- rst, in, 1, synchronous active-high reset.
- idelay_rdy, in, 1, IDELAYCTRL ready.
- train_start, in, 1, single-cycle pulse; starts or restarts training.
- data_in, in, 8, word from the deserializer.
- idelay_tap, out, 9, tap value to the IDELAY CNTVALUEIN.
- data_aligned, out, 8, rotation-corrected word.
- data_valid, out, 1, high only in LOCKED.
- locked, out, 1, training succeeded.
- train_fail, out, 1, training failed; sticky until rst or train_start.
- rotation, out, 3, chosen word rotation.
- eye_pts, out, 7, length of the best run, in tap points.

Behaviour:
- Reset value of all outputs is 0, except idelay_tap = TAP_INIT.
- rst at any point, including mid-sweep, returns to IDLE and clears the best/current run registers.
- Alignment window: data_prev registers data_in every cycle. window = {data_in, data_prev}, 16 bits. Slice(r) = window[r+7:r], for r = 0..7.
- data_aligned is registered Slice(rotation), so latency is 1 cycle from data_in. It updates every cycle; consumers qualify it with data_valid.
- State machine:
  - IDLE: on train_start go to WAIT_RDY.
  - WAIT_RDY: hold until idelay_rdy = 1. Then tap = 0, clear runs, go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to SAMPLE.
  - SAMPLE:
    - First cycle: find the lowest r with Slice(r) == PATTERN. If none, the point fails.
    - Remaining cycles: the point passes only if Slice(r) == PATTERN on all SAMPLE_CYCLES cycles, using the same r.
    - Then go to EVAL.
  - EVAL (1 cycle), run tracking:
    - Pass with cur_len > 0 and r == cur_rot: cur_len++.
    - Pass otherwise: start a new run with cur_start = tap, cur_len = 1, cur_rot = r.
    - Fail: cur_len = 0.
    - Whenever cur_len (after update) is strictly greater than best_len, copy the current run to best. The first longest run wins ties.
    - If tap + TAP_STEP > TAP_MAX, go to DECIDE. Otherwise tap += TAP_STEP and go to SETTLE.
  - DECIDE:
    - If best_len < MIN_EYE_PTS, go to FAIL.
    - Otherwise tap = best_start + (((best_len-1)*TAP_STEP) >> 1), rotation = best_rot, eye_pts = best_len, then go to VERIFY_SETTLE.
  - VERIFY_SETTLE: wait SETTLE_CYCLES, then go to VERIFY.
  - VERIFY: SAMPLE_CYCLES consecutive matches of Slice(rotation) are required. All match: go to LOCKED. Any mismatch: go to FAIL.
  - LOCKED: locked = 1, data_valid = 1. No pattern monitoring. train_start returns to WAIT_RDY and clears locked, data_valid and eye_pts.
  - FAIL: train_fail = 1, idelay_tap = TAP_INIT. train_start returns to WAIT_RDY and clears train_fail.
- idelay_rdy dropping outside IDLE/LOCKED/FAIL aborts to WAIT_RDY and restarts the sweep from tap 0.
- train_start in any training state restarts from WAIT_RDY.
- Tap arithmetic uses 10 bits internally, so the sweep-end compare cannot wrap.

Test Plan:
- Bench eye model: taps 100..300 pass at rotation 3, others random; pulse train_start. Required: best_start = 104, eye_pts = 25, idelay_tap = 200, rotation = 3, locked = 1. data_aligned equals source words delayed by 1 cycle.
- No passing taps anywhere. Required: train_fail = 1 after the sweep finishes at tap 504, idelay_tap = 256, locked = 0, data_valid = 0.
- Two eyes: taps 40..80 and 200..360. Required: second eye chosen, eye_pts = 21, idelay_tap = 280.
- Eye 100..300 where rotation switches from 3 to 5 at tap 200. Required: runs split, best is the first-longest run, idelay_tap and rotation come from that run.
- idelay_rdy held 0 for 50 cycles after train_start. Required: idelay_tap stays 256 and no sweep occurs. After rdy rises, the sweep starts at tap 0.
- rst asserted mid-sweep at tap 160. Required: next cycle all outputs are at reset values and the state is IDLE. A subsequent train_start gives a full clean retrain.

Source files
------------

// File: rtl/lvds_link_trainer.sv
// lvds_link_trainer: IDELAY tap sweep, eye centring and word alignment
// for an 8:1 LVDS deserializer in the clk_parallel domain.
module lvds_link_trainer #(
  parameter logic [7:0] PATTERN       = 8'h5C,
  parameter int         TAP_INIT      = 256,
  parameter int         TAP_STEP      = 8,
  parameter int         TAP_MAX       = 511,
  parameter int         SETTLE_CYCLES = 8,
  parameter int         SAMPLE_CYCLES = 16,
  parameter int         MIN_EYE_PTS   = 4
) (
  input  logic       clk_parallel,
  input  logic       rst,
  input  logic       idelay_rdy,
  input  logic       train_start,
  input  logic [7:0] data_in,
  output logic [8:0] idelay_tap,
  output logic [7:0] data_aligned,
  output logic       data_valid,
  output logic       locked,
  output logic       train_fail,
  output logic [2:0] rotation,
  output logic [6:0] eye_pts
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_SETTLE, S_SAMPLE, S_EVAL,
    S_DECIDE, S_VSETTLE, S_VERIFY, S_LOCKED, S_FAIL
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] tap_q, tap_d;
  logic [4:0] cnt_q, cnt_d;
  logic       pass_q, pass_d;
  logic [2:0] samp_rot_q, samp_rot_d;
  logic [6:0] cur_len_q, cur_len_d;
  logic [6:0] best_len_q, best_len_d;
  logic [9:0] cur_start_q, cur_start_d;
  logic [9:0] best_start_q, best_start_d;
  logic [2:0] cur_rot_q, cur_rot_d;
  logic [2:0] best_rot_q, best_rot_d;
  logic [2:0] rot_q, rot_d;
  logic [6:0] eye_q, eye_d;
  logic [7:0] data_prev_q, data_prev_d;
  logic [7:0] align_q, align_d;

  logic [15:0] window;
  logic [7:0]  hit;
  logic        any_hit;
  logic [2:0]  low_rot;
  logic [9:0]  tap_next;
  logic [9:0]  half_span;
  logic [6:0]  len_m1;
  logic        training;

  // hit[r] flags Slice(r) == PATTERN; low_rot is the lowest such r
  always_comb begin
    window  = {data_in, data_prev_q};
    hit     = '0;
    low_rot = '0;
    for (int r = 0; r < 8; r++) begin
      hit[r] = window[r +: 8] == PATTERN;
    end
    for (int r = 7; r >= 0; r--) begin
      if (hit[r]) low_rot = 3'(r);
    end
    any_hit = |hit;
  end

  always_ff @(posedge clk_parallel) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tap_q        <= 10'(TAP_INIT);
      cnt_q        <= '0;
      pass_q       <= 1'b0;
      samp_rot_q   <= '0;
      cur_len_q    <= '0;
      best_len_q   <= '0;
      cur_start_q  <= '0;
      best_start_q <= '0;
      cur_rot_q    <= '0;
      best_rot_q   <= '0;
      rot_q        <= '0;
      eye_q        <= '0;
      data_prev_q  <= '0;
      align_q      <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      pass_q       <= pass_d;
      samp_rot_q   <= samp_rot_d;
      cur_len_q    <= cur_len_d;
      best_len_q   <= best_len_d;
      cur_start_q  <= cur_start_d;
      best_start_q <= best_start_d;
      cur_rot_q    <= cur_rot_d;
      best_rot_q   <= best_rot_d;
      rot_q        <= rot_d;
      eye_q        <= eye_d;
      data_prev_q  <= data_prev_d;
      align_q      <= align_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    pass_d       = pass_q;
    samp_rot_d   = samp_rot_q;
    cur_len_d    = cur_len_q;
    best_len_d   = best_len_q;
    cur_start_d  = cur_start_q;
    best_start_d = best_start_q;
    cur_rot_d    = cur_rot_q;
    best_rot_d   = best_rot_q;
    rot_d        = rot_q;
    eye_d        = eye_q;
    data_prev_d  = data_in;
    align_d      = window[rot_q +: 8];
    tap_next     = tap_q + 10'(TAP_STEP);
    len_m1       = best_len_q - 7'd1;
    half_span    = 10'(({3'b000, len_m1} * 10'(TAP_STEP)) >> 1);
    training     = !(state_q inside {S_IDLE, S_LOCKED, S_FAIL});

    unique case (state_q)
      S_IDLE: begin
        if (train_start) state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (idelay_rdy) begin
          tap_d        = '0;
          cur_len_d    = '0;
          best_len_d   = '0;
          cur_start_d  = '0;
          best_start_d = '0;
          cur_rot_d    = '0;
          best_rot_d   = '0;
          cnt_d        = '0;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE, S_VSETTLE: begin
        if (cnt_q == 5'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (state_q == S_SETTLE) ? S_SAMPLE : S_VERIFY;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == '0) begin
          pass_d     = any_hit;
          samp_rot_d = low_rot;
        end else begin
          pass_d = pass_q & hit[samp_rot_q];
        end
        if (cnt_q == 5'(SAMPLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_EVAL: begin
        if (pass_q) begin
          if (cur_len_q != '0 && samp_rot_q == cur_rot_q) begin
            cur_len_d = cur_len_q + 7'd1;
          end else begin
            cur_start_d = tap_q;
            cur_len_d   = 7'd1;
            cur_rot_d   = samp_rot_q;
          end
        end else begin
          cur_len_d = '0;
        end
        // strict compare keeps the earliest of equally long runs
        if (cur_len_d > best_len_q) begin
          best_len_d   = cur_len_d;
          best_start_d = cur_start_d;
          best_rot_d   = cur_rot_d;
        end
        if (tap_next > 10'(TAP_MAX)) begin
          state_d = S_DECIDE;
        end else begin
          tap_d   = tap_next;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_DECIDE: begin
        if (best_len_q < 7'(MIN_EYE_PTS)) begin
          tap_d   = 10'(TAP_INIT);
          state_d = S_FAIL;
        end else begin
          tap_d   = best_start_q + half_span;
          rot_d   = best_rot_q;
          eye_d   = best_len_q;
          cnt_d   = '0;
          state_d = S_VSETTLE;
        end
      end
      S_VERIFY: begin
        if (!hit[rot_q]) begin
          tap_d   = 10'(TAP_INIT);
          state_d = S_FAIL;
        end else if (cnt_q == 5'(SAMPLE_CYCLES - 1)) begin
          state_d = S_LOCKED;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_LOCKED, S_FAIL: begin
        if (train_start) begin
          eye_d   = '0;
          state_d = S_WAIT_RDY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // restart or lost IDELAYCTRL during training re-enters the sweep
    if (training && (train_start || !idelay_rdy)) begin
      cnt_d   = '0;
      state_d = S_WAIT_RDY;
      if (train_start) eye_d = '0;
    end
  end

  always_comb begin
    locked       = state_q == S_LOCKED;
    data_valid   = state_q == S_LOCKED;
    train_fail   = state_q == S_FAIL;
    idelay_tap   = tap_q[8:0];
    data_aligned = align_q;
    rotation     = rot_q;
    eye_pts      = eye_q;
  end

endmodule

// File: tb/tb_lvds_link_trainer.sv
// tb_lvds_link_trainer: directed eye-model stimulus for lvds_link_trainer
// with hand-computed tap, rotation and eye width expectations.
module tb_lvds_link_trainer;

  localparam logic [7:0] PAT = 8'h5C;

  logic       clk_parallel = 1'b0;
  logic       rst          = 1'b1;
  logic       idelay_rdy   = 1'b0;
  logic       train_start  = 1'b0;
  logic [7:0] data_in      = '0;
  logic [8:0] idelay_tap;
  logic [7:0] data_aligned;
  logic       data_valid;
  logic       locked;
  logic       train_fail;
  logic [2:0] rotation;
  logic [6:0] eye_pts;

  int checks = 0;
  int errors = 0;

  int lo1 = 1000, hi1 = -1, rot_a = 3, split = 1000, rot_b = 3;
  int lo2 = 1000, hi2 = -1, rot2 = 3;
  bit stream_on = 1'b0;
  int sidx = 0;
  int last_tap = 0;
  int bad;

  always #5 clk_parallel = ~clk_parallel;

  lvds_link_trainer dut (
    .clk_parallel (clk_parallel),
    .rst          (rst),
    .idelay_rdy   (idelay_rdy),
    .train_start  (train_start),
    .data_in      (data_in),
    .idelay_tap   (idelay_tap),
    .data_aligned (data_aligned),
    .data_valid   (data_valid),
    .locked       (locked),
    .train_fail   (train_fail),
    .rotation     (rotation),
    .eye_pts      (eye_pts)
  );

  // deserializer word whose Slice(r) over {this, previous} is cur
  function automatic logic [7:0] rot_word(input logic [7:0] nxt,
                                          input logic [7:0] cur,
                                          input int r);
    logic [15:0] w;
    w = {nxt, cur} >> (8 - r);
    return w[7:0];
  endfunction

  function automatic logic [7:0] src_w(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  function automatic logic [7:0] eye_word(input int t);
    if (t >= lo1 && t <= hi1)
      return rot_word(PAT, PAT, (t >= split) ? rot_b : rot_a);
    if (t >= lo2 && t <= hi2)
      return rot_word(PAT, PAT, rot2);
    return 8'($urandom);
  endfunction

  always @(posedge clk_parallel) begin
    #1;
    if (stream_on) begin
      data_in = rot_word(src_w(sidx + 1), src_w(sidx), 3);
      sidx++;
    end else begin
      data_in = eye_word(int'(idelay_tap));
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tap"}, int'(idelay_tap), 256);
    check({tag, "_aligned"}, int'(data_aligned), 0);
    check({tag, "_valid"}, int'(data_valid), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_fail"}, int'(train_fail), 0);
    check({tag, "_rot"}, int'(rotation), 0);
    check({tag, "_eye"}, int'(eye_pts), 0);
  endtask

  task automatic set_eye(input int l1, input int h1, input int ra,
                         input int sp, input int rb,
                         input int l2, input int h2, input int r2);
    lo1 = l1; hi1 = h1; rot_a = ra; split = sp; rot_b = rb;
    lo2 = l2; hi2 = h2; rot2 = r2;
  endtask

  task automatic pulse_start();
    train_start = 1'b1;
    @(negedge clk_parallel);
    train_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(locked || train_fail) && n < 4000) begin
      last_tap = int'(idelay_tap);
      @(negedge clk_parallel);
      n++;
    end
    check({tag, "_done"}, int'(locked || train_fail), 1);
  endtask

  task automatic wait_tap(input string tag, input int t);
    int n;
    n = 0;
    while (int'(idelay_tap) != t && n < 4000) begin
      @(negedge clk_parallel);
      n++;
    end
    check(tag, int'(idelay_tap), t);
  endtask

  task automatic check_lock(input string tag, input int tap,
                            input int rot, input int eye);
    check({tag, "_locked"}, int'(locked), 1);
    check({tag, "_valid"}, int'(data_valid), 1);
    check({tag, "_tap"}, int'(idelay_tap), tap);
    check({tag, "_rot"}, int'(rotation), rot);
    check({tag, "_eye"}, int'(eye_pts), eye);
  endtask

  initial begin
    repeat (3) @(negedge clk_parallel);
    check_reset("rst");
    rst = 1'b0;
    idelay_rdy = 1'b1;
    @(negedge clk_parallel);

    // single eye 100..300 at rotation 3
    set_eye(100, 300, 3, 1000, 3, 1000, -1, 3);
    pulse_start();
    wait_done("eye1");
    check_lock("eye1", 200, 3, 25);
    check("eye1_fail", int'(train_fail), 0);

    sidx = 0;
    stream_on = 1'b1;
    repeat (3) @(negedge clk_parallel);
    for (int i = 0; i < 8; i++) begin
      check("stream", int'(data_aligned), int'(src_w(sidx - 2)));
      @(negedge clk_parallel);
    end
    stream_on = 1'b0;

    // no passing taps anywhere
    set_eye(1000, -1, 3, 1000, 3, 1000, -1, 3);
    pulse_start();
    check("restart_eye_clr", int'(eye_pts), 0);
    wait_done("none");
    check("none_fail", int'(train_fail), 1);
    check("none_last_tap", last_tap, 504);
    check("none_tap", int'(idelay_tap), 256);
    check("none_locked", int'(locked), 0);
    check("none_valid", int'(data_valid), 0);

    // two eyes, the wider second one wins
    set_eye(40, 80, 3, 1000, 3, 200, 360, 6);
    pulse_start();
    check("restart_fail_clr", int'(train_fail), 0);
    wait_done("two");
    check_lock("two", 280, 6, 21);

    // rotation change at 200 splits the eye; second run longer
    set_eye(100, 300, 3, 200, 5, 1000, -1, 3);
    pulse_start();
    wait_done("split");
    check_lock("split", 248, 5, 13);

    // equal-length split runs: the first one is kept
    set_eye(100, 295, 3, 200, 5, 1000, -1, 3);
    pulse_start();
    wait_done("tie");
    check_lock("tie", 148, 3, 12);

    // idelay_rdy low after train_start holds off the sweep
    rst = 1'b1;
    @(negedge clk_parallel);
    rst = 1'b0;
    idelay_rdy = 1'b0;
    set_eye(100, 300, 3, 1000, 3, 1000, -1, 3);
    pulse_start();
    bad = 0;
    repeat (50) begin
      if (int'(idelay_tap) != 256) bad++;
      @(negedge clk_parallel);
    end
    check("rdy_hold_bad", bad, 0);
    idelay_rdy = 1'b1;
    @(negedge clk_parallel);
    check("rdy_sweep_start", int'(idelay_tap), 0);
    wait_tap("rdy_tap80", 80);
    idelay_rdy = 1'b0;
    repeat (3) @(negedge clk_parallel);
    check("rdy_drop_hold", int'(idelay_tap), 80);
    idelay_rdy = 1'b1;
    @(negedge clk_parallel);
    check("rdy_drop_restart", int'(idelay_tap), 0);
    wait_done("rdy");
    check_lock("rdy", 200, 3, 25);

    // reset mid-sweep, then a clean retrain
    pulse_start();
    wait_tap("mid_tap160", 160);
    rst = 1'b1;
    @(negedge clk_parallel);
    check_reset("midrst");
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk_parallel);
      if (int'(idelay_tap) != 256 || locked || train_fail) bad++;
    end
    check("midrst_idle_bad", bad, 0);
    pulse_start();
    wait_done("retrain");
    check_lock("retrain", 200, 3, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
